// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: request, response and mem_sync-facing signals of the
// memory request front-end, bundled so the controller and its environment
// see opposite directions of the same wires.
interface mem_req_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    // Request port
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    // Read response port
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;

    // mem_sync side
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wd;
    logic          mem_wen;
    logic [DW-1:0] mem_rd;

    // Controller view
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rd,
        output req_ready, rsp_valid, rsp_data, rsp_addr,
               mem_address, mem_wd, mem_wen
    );

    // Requester / memory environment view
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rd,
        input  req_ready, rsp_valid, rsp_data, rsp_addr,
               mem_address, mem_wd, mem_wen
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: buffers read/write requests in a small in-order FIFO and
// turns each one into a single mem_sync access. Writes pulse mem_wen for
// one cycle and produce no response; reads wait out the memory latency and
// return data plus address over a valid/ready response port.
module mem_req_ctrl #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    mem_req_ctrl_if.slave               bus,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_WAIT,
        RSP
    } state_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    // Request FIFO
    req_t          fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Sequencer state and registered outputs
    state_e        state_q, state_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic          mem_wen_q, mem_wen_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0] rsp_addr_q, rsp_addr_d;

    logic push;
    logic pop;
    req_t head;

    // Ready depends on the registered count only, so a same-cycle pop never
    // opens the port early.
    assign bus.req_ready = (count_q < CW'(FIFO_DEPTH));
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (state_q == IDLE) && (count_q != '0);
    assign head          = fifo_q[rd_ptr_q];

    assign bus.mem_address = mem_address_q;
    assign bus.mem_wd      = mem_wd_q;
    assign bus.mem_wen     = mem_wen_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_addr    = rsp_addr_q;
    assign fifo_count      = count_q;
    assign busy            = (state_q != IDLE) || (count_q != '0);

    // Next-state logic for the FIFO pointers/count and the access sequencer.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        mem_address_d = mem_address_q;
        mem_wd_d      = mem_wd_q;
        mem_wen_d     = mem_wen_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_addr_d    = rsp_addr_q;

        // Pointers wrap naturally because the depth is a power of two.
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                mem_wen_d = 1'b0;
                if (pop) begin
                    mem_address_d = head.addr;
                    mem_wd_d      = head.wdata;
                    if (head.we) begin
                        mem_wen_d = 1'b1;
                        state_d   = WR;
                    end else begin
                        lat_cnt_d = LW'(RD_LAT);
                        state_d   = RD_WAIT;
                    end
                end
            end
            WR: begin
                // mem_sync commits the write on the edge that leaves WR.
                mem_wen_d = 1'b0;
                state_d   = IDLE;
            end
            RD_WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LW'(1);
                end else begin
                    rsp_data_d  = bus.mem_rd;
                    rsp_addr_d  = mem_address_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                // Response is held stable and no new pop happens until taken.
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and output registers; reset drops mem_wen immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            mem_address_q <= '0;
            mem_wd_q      <= '0;
            mem_wen_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_addr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            mem_address_q <= mem_address_d;
            mem_wd_q      <= mem_wd_d;
            mem_wen_q     <= mem_wen_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
        end
    end

    // Request storage: capture an accepted request at the tail pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the buffer is only a handful of entries, so it is cleared
            // on reset like every other register; a RAM-sized buffer would not be.
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= {bus.req_we, bus.req_addr, bus.req_wdata};
        end
    end
endmodule
